missile_launch_sched: RTL
=========================

# missile_launch_sched

Shares a pool of two missile slots between two shoot requesters: player key (requester 0) and auto-fire (requester 1). It arbitrates requests round-robin and issues a one-cycle fire pulse with latched launch coordinates to a free slot. It tracks each slot through flight and a tick-counted cooldown. It sits between the input/robot logic and the per-slot missile movers, and is the only source of their fire commands.

## Interface
Parameters:
- `CD_TICKS`, default 10: cooldown length in `tick_1hz` pulses; legal range 1..15.
- `SCREEN_W`, default 640: origins with x ≥ this are illegal.
- `SCREEN_H`, default 480: origins with y ≥ this are illegal.

Ports:
- `clk_22` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-cycle enable pulse, synchronous to `clk_22`; advances cooldowns.
- `req` in 2: level shoot request per requester; held until its `gnt`.
- `org_x0`, `org_y0` in 10 each: requester 0 launch origin.
- `org_x1`, `org_y1` in 10 each: requester 1 launch origin.
- `slot_done` in 2: per-slot pulse or level; the missile left the screen or hit a target.
- `gnt` out 2: one-hot, one-cycle grant to a requester.
- `fire` out 2: one-hot, one-cycle launch command to a slot.
- `l_x0`, `l_y0`, `l_x1`, `l_y1` out 10 each: per-slot latched launch position.
- `slot_busy` out 2: slot is FLYING.
- `cd_sign` out 1: no slot is FREE and at least one slot is in COOLDOWN.
- `free_cnt` out 2: number of FREE slots (0..2).

## Operation
- Per-slot FSM:
  - FREE → FLYING on its `fire`.
  - FLYING → COOLDOWN when `slot_done` is sampled high; the counter loads `CD_TICKS`.
  - COOLDOWN decrements on `tick_1hz`. The tick that sees count == 1 moves the slot to FREE.
  - `slot_done` is ignored in FREE and COOLDOWN.
- Eligibility: requester r is eligible when `req[r]` = 1, `gnt[r]` = 0 this cycle, and its origin is legal (x < `SCREEN_W`, y < `SCREEN_H`). An illegal origin is masked and never granted; its request stays pending.
- Grant decision, per cycle, using registered slot states:
  - Requires at least one eligible requester and at least one FREE slot.
  - Requester choice: round-robin pointer `rr`. The requester ≠ last granted wins a tie.
  - Slot choice: lowest-index FREE slot.
  - At most one grant per cycle.
- On grant:
  - Registered `gnt[r]` and `fire[s]` assert for exactly one cycle.
  - `l_x{s}`/`l_y{s}` take the origin of r, sampled at the same edge.
  - Slot s becomes FLYING.
  - `rr` points to the other requester.
- Both requesters pending with one FREE slot: only the `rr` winner is granted. The loser waits until a slot frees.
- A slot freed at edge N is grantable from the decision at edge N+1, never the same edge.
- `slot_done` and `fire` can never target the same slot in the same cycle, because `fire` only targets FREE slots.
- Arithmetic: cooldown counter is 4-bit unsigned. It does not decrement below 1 and never wraps.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - Both slots FREE; cooldown counters 0; `rr` = 0 (requester 0 favoured).
  - `gnt` = 0, `fire` = 0, `slot_busy` = 0, `cd_sign` = 0, `free_cnt` = 2.
  - `l_x*` = 100, `l_y*` = 140.
- Latency:
  - `req` high before edge N → `gnt`/`fire`/`l_*` valid in the cycle after edge N.
  - `slot_busy` rises at the same edge as `fire`.
- Requester handshake: drop `req` in the `gnt` cycle. If `req` is still high one cycle after `gnt`, it is a new request.
- `slot_done` at edge N → COOLDOWN at edge N+1.
- Cooldown exit: FREE exactly `CD_TICKS` tick pulses after entry. A tick in the entry cycle is not counted.
- Reset mid-flight or mid-cooldown: everything returns to reset values. No `fire` pulse follows reset release unless `req` is high.

## Structure
- Package `missile_pkg` holds:
  - slot state enum: FREE = 2'b00, FLYING = 2'b01, COOLDOWN = 2'b10;
  - screen constants 640/480;
  - reset origin 100/140;
  - the `CD_TICKS` default.
- Sub-module `missile_slot_ctrl`, instantiated twice: per-slot FSM, cooldown counter and launch-coordinate register. Inputs are `fire`/`slot_done`/`tick_1hz`/origin; outputs are state and coordinates.
- Top level holds eligibility masking, round-robin arbitration and the aggregate status outputs.

## Test plan
- Reset, then `req` = 01 with origin (100,140) → `gnt` = 01, `fire` = 01, `l_x0` = 100, `l_y0` = 140; `free_cnt` 2→1.
- `req` = 11 held, both slots FREE → requester 0 gets slot 0, then requester 1 gets slot 1 on consecutive grant cycles; `free_cnt` = 0.
- Both slots FLYING, `slot_done` = 01, then 10 ticks → slot 0 FREE after the 10th tick; `cd_sign` = 1 throughout; `slot_done` during COOLDOWN ignored.
- One FREE slot, `req` = 11, `rr` favouring requester 1 → only `gnt` = 10; requester 0 granted after the next slot frees.
- `org_x1` = 640 with `req` = 10 → no `gnt` ever. Changing the origin to (639,479) → granted next decision.
- `rst` asserted mid-cooldown with `req` low → all outputs return to reset values; no `fire` after release.

Source files
------------

// File: rtl/missile_pkg.sv
// ------------------------------------------------------------------
// missile_pkg : shared types and constants for the launch scheduler
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package missile_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    FLYING   = 2'b01,
    COOLDOWN = 2'b10
  } slot_state_e;

  localparam int          c_screen_w = 640;
  localparam int          c_screen_h = 480;
  localparam logic [9:0]  c_rst_x    = 10'd100;
  localparam logic [9:0]  c_rst_y    = 10'd140;
  localparam int          c_cd_ticks = 10;

endpackage

`default_nettype wire

// File: rtl/missile_slot_ctrl.sv
// ------------------------------------------------------------------
// missile_slot_ctrl : one missile slot (state, cooldown, launch coords)
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module missile_slot_ctrl
  import missile_pkg::*;
#(
  parameter int CD_TICKS = c_cd_ticks
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        launch_i,
  input  logic        done_i,
  input  logic        tick_i,
  input  logic [9:0]  org_x_i,
  input  logic [9:0]  org_y_i,
  output slot_state_e state_o,
  output logic [9:0]  lx_o,
  output logic [9:0]  ly_o
);

  localparam logic [3:0] c_cd_load = 4'(CD_TICKS);

  slot_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  lx_q, lx_d, ly_q, ly_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    case (state_q)
      FREE: begin
        if (launch_i) begin
          state_d = FLYING;
          lx_d    = org_x_i;
          ly_d    = org_y_i;
        end
      end
      FLYING: begin
        if (done_i) begin
          state_d = COOLDOWN;
          cnt_d   = c_cd_load;
        end
      end
      COOLDOWN: begin
        // The tick that sees a count of 1 releases the slot; never wraps below 1.
        if (tick_i) begin
          if (cnt_q <= 4'd1) begin
            state_d = FREE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FREE;
      cnt_q   <= 4'd0;
      lx_q    <= c_rst_x;
      ly_q    <= c_rst_y;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
    end
  end

  assign state_o = state_q;
  assign lx_o    = lx_q;
  assign ly_o    = ly_q;

endmodule

`default_nettype wire

// File: rtl/missile_launch_sched.sv
// ------------------------------------------------------------------
// missile_launch_sched : round-robin fire scheduler over two missile slots
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module missile_launch_sched
  import missile_pkg::*;
#(
  parameter int CD_TICKS = c_cd_ticks,
  parameter int SCREEN_W = c_screen_w,
  parameter int SCREEN_H = c_screen_h
) (
  input  logic       clk_22,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [1:0] req,
  input  logic [9:0] org_x0,
  input  logic [9:0] org_y0,
  input  logic [9:0] org_x1,
  input  logic [9:0] org_y1,
  input  logic [1:0] slot_done,
  output logic [1:0] gnt,
  output logic [1:0] fire,
  output logic [9:0] l_x0,
  output logic [9:0] l_y0,
  output logic [9:0] l_x1,
  output logic [9:0] l_y1,
  output logic [1:0] slot_busy,
  output logic       cd_sign,
  output logic [1:0] free_cnt
);

  localparam logic [10:0] c_lim_w = 11'(SCREEN_W);
  localparam logic [10:0] c_lim_h = 11'(SCREEN_H);

  logic [1:0]  gnt_q, gnt_d, fire_q, fire_d;
  logic        rr_q, rr_d;
  logic        win;
  logic [1:0]  legal, elig, free_vec, cool_vec;
  logic [9:0]  sel_x, sel_y;
  slot_state_e st [2];
  logic [9:0]  lx [2];
  logic [9:0]  ly [2];

  assign legal[0] = ({1'b0, org_x0} < c_lim_w) && ({1'b0, org_y0} < c_lim_h);
  assign legal[1] = ({1'b0, org_x1} < c_lim_w) && ({1'b0, org_y1} < c_lim_h);
  // A requester is masked in its own grant cycle so a held req is not double-granted.
  assign elig     = req & ~gnt_q & legal;

  always_comb begin
    gnt_d  = 2'b00;
    fire_d = 2'b00;
    rr_d   = rr_q;
    win    = (elig == 2'b11) ? rr_q : elig[1];
    if ((elig != 2'b00) && (free_vec != 2'b00)) begin
      gnt_d[win] = 1'b1;
      if (free_vec[0]) fire_d[0] = 1'b1;
      else             fire_d[1] = 1'b1;
      rr_d = ~win;
    end
  end

  assign sel_x = win ? org_x1 : org_x0;
  assign sel_y = win ? org_y1 : org_y0;

  always_ff @(posedge clk_22 or negedge rst) begin
    if (!rst) begin
      gnt_q  <= 2'b00;
      fire_q <= 2'b00;
      rr_q   <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      fire_q <= fire_d;
      rr_q   <= rr_d;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    missile_slot_ctrl #(
      .CD_TICKS (CD_TICKS)
    ) u_slot (
      .clk_i    (clk_22),
      .rst_ni   (rst),
      .launch_i (fire_d[s]),
      .done_i   (slot_done[s]),
      .tick_i   (tick_1hz),
      .org_x_i  (sel_x),
      .org_y_i  (sel_y),
      .state_o  (st[s]),
      .lx_o     (lx[s]),
      .ly_o     (ly[s])
    );
    assign free_vec[s]  = (st[s] == FREE);
    assign cool_vec[s]  = (st[s] == COOLDOWN);
    assign slot_busy[s] = (st[s] == FLYING);
  end

  assign gnt      = gnt_q;
  assign fire     = fire_q;
  assign l_x0     = lx[0];
  assign l_y0     = ly[0];
  assign l_x1     = lx[1];
  assign l_y1     = ly[1];
  assign cd_sign  = (free_vec == 2'b00) && (cool_vec != 2'b00);
  assign free_cnt = {1'b0, free_vec[0]} + {1'b0, free_vec[1]};

endmodule

`default_nettype wire
